// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared processor constants, opcode field and fetch FSM states
package instruction_fetch_unit_pkg;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;
  localparam int         OPCODE_MSB      = 31;
  localparam int         OPCODE_LSB      = 26;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory, redirect and decode handshake bundle
interface instruction_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc,
    input  imem_data, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc,
    output imem_data, branch_taken, branch_target, id_ready
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register, single-entry decode holding slot and RUN/HALT fetch FSM
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter logic [5:0]  HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus,
  output logic                      halted
);

  fetch_state_t state, next_state;
  logic [31:0]  pc;
  logic         id_valid_q;
  logic [31:0]  id_instr_q;
  logic [31:0]  id_pc_q;
  logic         fetch_en;
  logic         is_halt_op;

  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign halted        = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    is_halt_op = (opcode_of(bus.imem_data) == HALT_OP);
    fetch_en   = (state == RUN) && (!id_valid_q || bus.id_ready) && !bus.branch_taken;
    if (fetch_en && is_halt_op) next_state = HALT;
  end

  // A redirect wins over fetch, hold and halt detection; HALT ignores it entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'd0;
      id_pc_q    <= 32'd0;
    end else if (state == RUN) begin
      if (bus.branch_taken) begin
        pc         <= bus.branch_target;
        id_valid_q <= 1'b0;
      end else if (fetch_en) begin
        id_instr_q <= bus.imem_data;
        id_pc_q    <= pc;
        id_valid_q <= 1'b1;
        if (!is_halt_op) pc <= pc + PC_STEP;
      end
    end else if (bus.id_ready) begin
      id_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and randomized checks of the fetch unit against a behavioural model
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted, halted2;
  logic [31:0] mem [64];

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();

  instruction_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted));
  instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFF)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .halted(halted2));

  assign bus.imem_data  = mem[bus.imem_addr[5:0]];
  assign bus2.imem_data = mem[bus2.imem_addr[5:0]];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a program counter plus one "slot" holding what decode currently sees.
  logic [31:0] m_pc, m_instr, m_idpc;
  bit          m_valid, m_halt;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] word;
    if (!rst_n) begin
      m_pc = 32'd0; m_valid = 0; m_instr = 0; m_idpc = 0; m_halt = 0;
    end else begin
      word = mem[m_pc[5:0]];
      if (m_halt) begin
        if (bus.id_ready) m_valid = 0;
      end else if (bus.branch_taken) begin
        m_pc = bus.branch_target;
        m_valid = 0;
      end else if (!m_valid || bus.id_ready) begin
        m_instr = word;
        m_idpc  = m_pc;
        m_valid = 1;
        if (word[31:26] == 6'b111111) m_halt = 1;
        else m_pc = m_pc + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_imem_addr", bus.imem_addr, m_pc);
      chk("cmp_id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
      chk("cmp_id_instr", bus.id_instr, m_instr);
      chk("cmp_id_pc", bus.id_pc, m_idpc);
      chk("cmp_halted", {31'd0, halted}, {31'd0, m_halt});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    bus.id_ready = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus2.id_ready = 1'b1; bus2.branch_taken = 1'b0; bus2.branch_target = 32'd0;
    run_cmp = 1'b1;
    repeat (2) step();
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst2_imem_addr", bus2.imem_addr, 32'hFFFFFFFF);
    rst_n = 1'b1;

    // sequential fetch, then a 3-cycle stall at id_pc 2
    step();
    chk("seq_id_instr0", bus.id_instr, 32'h1000_0000);
    chk("seq_id_pc0", bus.id_pc, 32'd0);
    chk("wrap_id_pc_a", bus2.id_pc, 32'hFFFFFFFF);
    step();
    chk("seq_id_pc1", bus.id_pc, 32'd1);
    chk("wrap_id_pc_b", bus2.id_pc, 32'h0);
    step();
    chk("seq_id_pc2", bus.id_pc, 32'd2);
    chk("seq_imem_addr3", bus.imem_addr, 32'd3);
    bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_imem_addr", bus.imem_addr, 32'd3);
      chk("stall_id_pc", bus.id_pc, 32'd2);
      chk("stall_id_valid", {31'd0, bus.id_valid}, 32'd1);
    end
    bus.id_ready = 1'b1;
    step();
    chk("release_id_pc", bus.id_pc, 32'd3);
    chk("release_id_instr", bus.id_instr, 32'h1000_0003);

    // branch at id_pc 1
    do_reset();
    step(); step();
    chk("pre_branch_id_pc", bus.id_pc, 32'd1);
    bus.branch_taken = 1'b1; bus.branch_target = 32'd40;
    step();
    chk("branch_bubble_valid", {31'd0, bus.id_valid}, 32'd0);
    bus.branch_taken = 1'b0;
    step();
    chk("branch_id_pc", bus.id_pc, 32'd40);
    chk("branch_imem_addr", bus.imem_addr, 32'd41);
    chk("branch_id_instr", bus.id_instr, 32'h1000_0028);

    // halt on word 5, redirects ignored afterwards
    mem[5] = 32'hFC00_0000;
    do_reset();
    repeat (6) step();
    chk("halt_id_instr", bus.id_instr, 32'hFC00_0000);
    chk("halt_id_pc", bus.id_pc, 32'd5);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_imem_addr", bus.imem_addr, 32'd5);
    bus.branch_taken = 1'b1; bus.branch_target = 32'd20;
    step();
    chk("halt_accept_valid", {31'd0, bus.id_valid}, 32'd0);
    step();
    chk("halt_branch_ignored", bus.imem_addr, 32'd5);
    chk("halt_still", {31'd0, halted}, 32'd1);
    bus.branch_taken = 1'b0;

    // asynchronous reset in the middle of a stall
    do_reset();
    step(); step();
    bus.id_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("async_rst_pc", bus.imem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    step();
    chk("after_rst_id_pc", bus.id_pc, 32'd0);
    chk("after_rst_valid", {31'd0, bus.id_valid}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'b111111;
      else if (w[31:26] == 6'b111111) w[31:26] = 6'b000000;
      mem[i] = w;
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < (m_halt ? 10 : 1)) rst_n = 1'b0;
      else rst_n = 1'b1;
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       bus.branch_target = $urandom;
        1:       bus.branch_target = 32'hFFFFFFFE;
        default: bus.branch_target = $urandom_range(0, 63);
      endcase
      step();
    end
    run_cmp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
